// File: rtl/iir_coeff_ctrl_pkg.sv
// Shared definitions for the even/odd biquad coefficient controller:
// coefficient addresses, controller states and the unity helper.
package iir_ctrl_pkg;

    localparam int NUM_COEFF = 10;

    localparam logic [3:0] ADDR_B0_EVEN = 4'd0;
    localparam logic [3:0] ADDR_B1_EVEN = 4'd1;
    localparam logic [3:0] ADDR_B2_EVEN = 4'd2;
    localparam logic [3:0] ADDR_A1_EVEN = 4'd3;
    localparam logic [3:0] ADDR_A2_EVEN = 4'd4;
    localparam logic [3:0] ADDR_B0_ODD  = 4'd5;
    localparam logic [3:0] ADDR_B1_ODD  = 4'd6;
    localparam logic [3:0] ADDR_B2_ODD  = 4'd7;
    localparam logic [3:0] ADDR_A1_ODD  = 4'd8;
    localparam logic [3:0] ADDR_A2_ODD  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLUSH = 2'd2,
        ACK   = 2'd3
    } state_t;

    // 1.0 in signed Q2.(width-2)
    function automatic int UNITY(input int width);
        return 1 << (width - 2);
    endfunction

endpackage

// File: rtl/iir_coeff_ctrl_if.sv
// Host-side port of the coefficient controller: coefficient write
// handshake plus the commit request/acknowledge pair.
interface iir_coeff_ctrl_if #(
    parameter int COEFF_WIDTH = 16
);
    logic                          wr_valid;
    logic                          wr_ready;
    logic [3:0]                    wr_addr;
    logic signed [COEFF_WIDTH-1:0] wr_data;
    logic                          commit_req;
    logic                          commit_ack;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req,
        input  wr_ready, commit_ack
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req,
        output wr_ready, commit_ack
    );
endinterface

// File: rtl/iir_coeff_bank.sv
// Shadow and active coefficient register files with the per-entry dirty
// mask. Writes land in the shadow bank; a swap copies the whole shadow
// bank to the active bank in one edge so outputs never see a partial set.
module iir_coeff_bank
    import iir_ctrl_pkg::*;
#(
    parameter int COEFF_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  logic [3:0]                    i_wr_addr,
    input  logic signed [COEFF_WIDTH-1:0] i_wr_data,
    input  logic                          i_swap,
    output logic signed [COEFF_WIDTH-1:0] o_active [NUM_COEFF],
    output logic                          o_dirty_any
);

    logic signed [COEFF_WIDTH-1:0] r_shadow [NUM_COEFF];
    logic signed [COEFF_WIDTH-1:0] r_active [NUM_COEFF];
    logic [NUM_COEFF-1:0]          r_dirty;

    // Passthrough: b0 = 1.0 on both phases, everything else zero
    function automatic logic signed [COEFF_WIDTH-1:0] reset_val(input int idx);
        if (idx == int'(ADDR_B0_EVEN) || idx == int'(ADDR_B0_ODD))
            return COEFF_WIDTH'(UNITY(COEFF_WIDTH));
        return '0;
    endfunction

    // Shadow bank and dirty mask; the shadow keeps its contents across swaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFF; i++) r_shadow[i] <= reset_val(i);
            r_dirty <= '0;
        end else begin
            if (i_swap) r_dirty <= '0;
            if (i_wr_en) begin
                r_shadow[i_wr_addr] <= i_wr_data;
                r_dirty[i_wr_addr]  <= 1'b1;
            end
        end
    end

    // Active bank: whole-bank copy on the swap strobe only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFF; i++) r_active[i] <= reset_val(i);
        end else if (i_swap) begin
            r_active <= r_shadow;
        end
    end

    assign o_active    = r_active;
    assign o_dirty_any = |r_dirty;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient bank controller for the even/odd polyphase biquad pair.
// Accepts host writes into a shadow bank, commits them on a sample-pair
// boundary, optionally flushes the biquads, then acknowledges the commit.
module iir_coeff_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int COEFF_WIDTH   = 16,
    parameter int FLUSH_ON_SWAP = 1,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    iir_coeff_ctrl_if.slave               host,
    input  logic                          sample_tick,
    output logic signed [COEFF_WIDTH-1:0] b0_even,
    output logic signed [COEFF_WIDTH-1:0] b1_even,
    output logic signed [COEFF_WIDTH-1:0] b2_even,
    output logic signed [COEFF_WIDTH-1:0] a1_even,
    output logic signed [COEFF_WIDTH-1:0] a2_even,
    output logic signed [COEFF_WIDTH-1:0] b0_odd,
    output logic signed [COEFF_WIDTH-1:0] b1_odd,
    output logic signed [COEFF_WIDTH-1:0] b2_odd,
    output logic signed [COEFF_WIDTH-1:0] a1_odd,
    output logic signed [COEFF_WIDTH-1:0] a2_odd,
    output logic                          filt_clear,
    output logic                          busy,
    output logic                          err_addr
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t                        r_state;
    logic                          r_wr_ready;
    logic                          r_commit_ack;
    logic                          r_filt_clear;
    logic                          r_busy;
    logic                          r_err_addr;
    logic [CNT_W-1:0]              r_cnt;

    logic                          w_wr_accept;
    logic                          w_addr_ok;
    logic                          w_wr_en;
    logic                          w_swap;
    logic                          w_dirty_any;
    logic                          w_dirty_next;
    logic signed [COEFF_WIDTH-1:0] w_active [NUM_COEFF];

    assign w_wr_accept  = host.wr_valid && r_wr_ready;
    assign w_addr_ok    = host.wr_addr < 4'(NUM_COEFF);
    assign w_wr_en      = w_wr_accept && w_addr_ok;
    assign w_swap       = (r_state == ARMED) && sample_tick;
    // A write arriving with commit_req is part of that commit
    assign w_dirty_next = w_dirty_any || w_wr_en;

    iir_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (host.wr_addr),
        .i_wr_data   (host.wr_data),
        .i_swap      (w_swap),
        .o_active    (w_active),
        .o_dirty_any (w_dirty_any)
    );

    // Commit FSM with registered handshake, flush and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_ready   <= 1'b1;
            r_commit_ack <= 1'b0;
            r_filt_clear <= 1'b0;
            r_busy       <= 1'b0;
            r_err_addr   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (host.commit_req) begin
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_dirty_next) begin
                            r_state <= ARMED;
                        end else begin
                            r_state      <= ACK;
                            r_commit_ack <= 1'b1;
                            r_err_addr   <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    if (sample_tick) begin
                        if (FLUSH_ON_SWAP != 0) begin
                            r_state      <= FLUSH;
                            r_filt_clear <= 1'b1;
                            r_cnt        <= CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            r_state      <= ACK;
                            r_commit_ack <= 1'b1;
                            r_err_addr   <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state      <= ACK;
                        r_filt_clear <= 1'b0;
                        r_commit_ack <= 1'b1;
                        r_err_addr   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    r_state      <= IDLE;
                    r_commit_ack <= 1'b0;
                    r_busy       <= 1'b0;
                    r_wr_ready   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            // Out-of-range write is dropped but flagged; it wins over a same-cycle clear
            if (w_wr_accept && !w_addr_ok) r_err_addr <= 1'b1;
        end
    end

    assign host.wr_ready   = r_wr_ready;
    assign host.commit_ack = r_commit_ack;
    assign filt_clear      = r_filt_clear;
    assign busy            = r_busy;
    assign err_addr        = r_err_addr;

    assign b0_even = w_active[ADDR_B0_EVEN];
    assign b1_even = w_active[ADDR_B1_EVEN];
    assign b2_even = w_active[ADDR_B2_EVEN];
    assign a1_even = w_active[ADDR_A1_EVEN];
    assign a2_even = w_active[ADDR_A2_EVEN];
    assign b0_odd  = w_active[ADDR_B0_ODD];
    assign b1_odd  = w_active[ADDR_B1_ODD];
    assign b2_odd  = w_active[ADDR_B2_ODD];
    assign a1_odd  = w_active[ADDR_A1_ODD];
    assign a2_odd  = w_active[ADDR_A2_ODD];

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Bench for iir_coeff_ctrl: per-cycle vector table for the main commit
// flows, plus hand sequences for reset, reset-during-flush and the
// no-flush build.
module tb_iir_coeff_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT 1: flush enabled
    iir_coeff_ctrl_if #(.COEFF_WIDTH(16)) bus ();
    logic        st;
    logic signed [15:0] b0e, b1e, b2e, a1e, a2e, b0o, b1o, b2o, a1o, a2o;
    logic        clr, bsy, err;

    iir_coeff_ctrl #(.COEFF_WIDTH(16), .FLUSH_ON_SWAP(1), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus), .sample_tick(st),
        .b0_even(b0e), .b1_even(b1e), .b2_even(b2e), .a1_even(a1e), .a2_even(a2e),
        .b0_odd(b0o), .b1_odd(b1o), .b2_odd(b2o), .a1_odd(a1o), .a2_odd(a2o),
        .filt_clear(clr), .busy(bsy), .err_addr(err)
    );

    // DUT 2: no flush after swap
    iir_coeff_ctrl_if #(.COEFF_WIDTH(16)) bus2 ();
    logic        st2;
    logic signed [15:0] c_b0e, c_b1e, c_b2e, c_a1e, c_a2e, c_b0o, c_b1o, c_b2o, c_a1o, c_a2o;
    logic        clr2, bsy2, err2;

    iir_coeff_ctrl #(.COEFF_WIDTH(16), .FLUSH_ON_SWAP(0), .FLUSH_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .host(bus2), .sample_tick(st2),
        .b0_even(c_b0e), .b1_even(c_b1e), .b2_even(c_b2e), .a1_even(c_a1e), .a2_even(c_a2e),
        .b0_odd(c_b0o), .b1_odd(c_b1o), .b2_odd(c_b2o), .a1_odd(c_a1o), .a2_odd(c_a2o),
        .filt_clear(clr2), .busy(bsy2), .err_addr(err2)
    );

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        cr;
        logic        tk;
        logic        rdy, bsy, clr, ack, err;
        logic [15:0] b0e, a1e, a2e, a1o;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                                input logic cr, input logic tk,
                                input logic rdy, input logic bs, input logic cl,
                                input logic ak, input logic er,
                                input logic [15:0] e_b0e, input logic [15:0] e_a1e,
                                input logic [15:0] e_a2e, input logic [15:0] e_a1o);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.cr = cr; v.tk = tk;
        v.rdy = rdy; v.bsy = bs; v.clr = cl; v.ack = ak; v.err = er;
        v.b0e = e_b0e; v.a1e = e_a1e; v.a2e = e_a2e; v.a1o = e_a1o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                          input logic cr, input logic tk);
        bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
        bus.commit_req = cr; st = tk;
    endtask

    task automatic drive2(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                          input logic cr, input logic tk);
        bus2.wr_valid = wv; bus2.wr_addr = wa; bus2.wr_data = wd;
        bus2.commit_req = cr; st2 = tk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive1(0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0);

        // cycle-by-cycle vectors: inputs before edge i, outputs after edge i
        //             wv wa     wd        cr tk  rdy bsy clr ack err  b0e       a1e       a2e       a1o
        tbl[0]  = mk(1, 4'd0,  16'h2000, 0, 0,  1, 0, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(1, 4'd8,  16'hC000, 0, 0,  1, 0, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[4]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[5]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[6]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h4000, 16'h0000, 16'h0000, 16'h0000);
        tbl[7]  = mk(0, 4'd0,  16'h0000, 1, 1,  0, 1, 1, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[8]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 1, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[9]  = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 1, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[10] = mk(0, 4'd0,  16'h0000, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[11] = mk(0, 4'd0,  16'h0000, 0, 1,  1, 0, 0, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[12] = mk(1, 4'd3,  16'h1234, 1, 0,  0, 1, 0, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[13] = mk(1, 4'd4,  16'h7777, 1, 0,  0, 1, 0, 0, 0,  16'h2000, 16'h0000, 16'h0000, 16'hC000);
        tbl[14] = mk(1, 4'd4,  16'h7777, 1, 1,  0, 1, 1, 0, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[15] = mk(1, 4'd4,  16'h7777, 1, 0,  0, 1, 1, 0, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[16] = mk(1, 4'd4,  16'h7777, 1, 0,  0, 1, 0, 1, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[17] = mk(1, 4'd4,  16'h7777, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[18] = mk(1, 4'd4,  16'h7777, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[19] = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 0, 0,  16'h2000, 16'h1234, 16'h0000, 16'hC000);
        tbl[20] = mk(0, 4'd0,  16'h0000, 1, 1,  0, 1, 1, 0, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[21] = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 1, 0, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[22] = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 1, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[23] = mk(0, 4'd0,  16'h0000, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[24] = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 1, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[25] = mk(0, 4'd0,  16'h0000, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[26] = mk(1, 4'd12, 16'h5555, 0, 0,  1, 0, 0, 0, 1,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[27] = mk(0, 4'd0,  16'h0000, 0, 0,  1, 0, 0, 0, 1,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[28] = mk(0, 4'd0,  16'h0000, 1, 0,  0, 1, 0, 1, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);
        tbl[29] = mk(0, 4'd0,  16'h0000, 0, 0,  1, 0, 0, 0, 0,  16'h2000, 16'h1234, 16'h7777, 16'hC000);

        // reset and passthrough state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst b0_even", b0e, 16'h4000);
        chk("rst b1_even", b1e, 16'h0000);
        chk("rst b2_even", b2e, 16'h0000);
        chk("rst a1_even", a1e, 16'h0000);
        chk("rst a2_even", a2e, 16'h0000);
        chk("rst b0_odd",  b0o, 16'h4000);
        chk("rst b1_odd",  b1o, 16'h0000);
        chk("rst b2_odd",  b2o, 16'h0000);
        chk("rst a1_odd",  a1o, 16'h0000);
        chk("rst a2_odd",  a2o, 16'h0000);
        chk("rst wr_ready", 16'(bus.wr_ready), 16'h1);
        chk("rst busy", 16'(bsy), 16'h0);
        chk("rst filt_clear", 16'(clr), 16'h0);
        chk("rst commit_ack", 16'(bus.commit_ack), 16'h0);
        chk("rst err_addr", 16'(err), 16'h0);

        // table-driven main flows
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive1(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].cr, tbl[i].tk);
            @(posedge clk); #1;
            chk($sformatf("row%0d wr_ready", i),   16'(bus.wr_ready),   16'(tbl[i].rdy));
            chk($sformatf("row%0d busy", i),       16'(bsy),            16'(tbl[i].bsy));
            chk($sformatf("row%0d filt_clear", i), 16'(clr),            16'(tbl[i].clr));
            chk($sformatf("row%0d commit_ack", i), 16'(bus.commit_ack), 16'(tbl[i].ack));
            chk($sformatf("row%0d err_addr", i),   16'(err),            16'(tbl[i].err));
            chk($sformatf("row%0d b0_even", i),    b0e,                 tbl[i].b0e);
            chk($sformatf("row%0d a1_even", i),    a1e,                 tbl[i].a1e);
            chk($sformatf("row%0d a2_even", i),    a2e,                 tbl[i].a2e);
            chk($sformatf("row%0d a1_odd", i),     a1o,                 tbl[i].a1o);
        end
        chk("tbl b1_odd untouched", b1o, 16'h0000);
        chk("tbl b0_odd untouched", b0o, 16'h4000);

        // reset asserted mid-flush restores passthrough without a clock edge
        @(negedge clk); drive1(1, 4'd5, 16'h1111, 0, 0);
        @(negedge clk); drive1(0, 4'd0, 16'h0000, 1, 0);
        @(negedge clk); drive1(0, 4'd0, 16'h0000, 1, 1);
        @(posedge clk); #1;
        chk("flush filt_clear", 16'(clr), 16'h1);
        chk("flush b0_odd", b0o, 16'h1111);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst filt_clear", 16'(clr), 16'h0);
        chk("async rst b0_even", b0e, 16'h4000);
        chk("async rst b0_odd", b0o, 16'h4000);
        chk("async rst a1_odd", a1o, 16'h0000);
        chk("async rst a1_even", a1e, 16'h0000);
        chk("async rst busy", 16'(bsy), 16'h0);
        chk("async rst wr_ready", 16'(bus.wr_ready), 16'h1);
        drive1(0, 4'd0, 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst commit_ack", 16'(bus.commit_ack), 16'h0);
        chk("post rst b0_odd", b0o, 16'h4000);

        // no-flush build: commit_ack in the cycle after the tick
        @(negedge clk); drive2(1, 4'd1, 16'h0100, 0, 0);
        @(negedge clk); drive2(0, 4'd0, 16'h0000, 1, 0);
        @(posedge clk); #1;
        chk("noflush armed busy", 16'(bsy2), 16'h1);
        chk("noflush armed b1_even", c_b1e, 16'h0000);
        @(negedge clk); drive2(0, 4'd0, 16'h0000, 1, 1);
        @(posedge clk); #1;
        chk("noflush commit_ack", 16'(bus2.commit_ack), 16'h1);
        chk("noflush filt_clear", 16'(clr2), 16'h0);
        chk("noflush b1_even", c_b1e, 16'h0100);
        chk("noflush b0_even", c_b0e, 16'h4000);
        @(negedge clk); drive2(0, 4'd0, 16'h0000, 0, 0);
        @(posedge clk); #1;
        chk("noflush idle ack", 16'(bus2.commit_ack), 16'h0);
        chk("noflush idle busy", 16'(bsy2), 16'h0);
        chk("noflush idle wr_ready", 16'(bus2.wr_ready), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_coeff_ctrl.md
# iir_coeff_ctrl

Coefficient bank controller for the even/odd polyphase biquad pair. It accepts coefficient writes from a host over a valid/ready port into a shadow bank, then commits the shadow bank to the active outputs only on a sample-pair boundary. After each swap it optionally pulses a flush to the biquads so that state built under old coefficients cannot ring. It sits between the host/register interface and the ten coefficient inputs of the even/odd IIR.

## Interface
- COEFF_WIDTH, 16: coefficient width, signed Q2.(COEFF_WIDTH-2).
- FLUSH_ON_SWAP, 1: 1 = assert filt_clear after every swap; 0 = no flush.
- FLUSH_CYCLES, 2: filt_clear pulse length in cycles, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  coefficient write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  4  coefficient index; 0–4 = even b0,b1,b2,a1,a2; 5–9 = odd b0,b1,b2,a1,a2.
- wr_data  in  COEFF_WIDTH  coefficient value.
- commit_req  in  1  request to apply the shadow bank.
- commit_ack  out  1  one-cycle pulse when the commit is complete.
- sample_tick  in  1  one-cycle strobe marking the start of an even/odd sample pair.
- b0_even, b1_even, b2_even, a1_even, a2_even  out  COEFF_WIDTH each  active even coefficients.
- b0_odd, b1_odd, b2_odd, a1_odd, a2_odd  out  COEFF_WIDTH each  active odd coefficients.
- filt_clear  out  1  flush request to both biquads.
- busy  out  1  high in every state except IDLE.
- err_addr  out  1  sticky flag, set by a write to address 10–15.

## Operation
- **Reset values.** Shadow and active banks reset to passthrough: b0 = UNITY = 1 << (COEFF_WIDTH-2), all other coefficients 0. dirty = 0. State IDLE. All control outputs 0, except wr_ready = 1.
- **FSM states:** IDLE, ARMED, FLUSH, ACK.
- **IDLE.**
  - wr_ready = 1.
  - An accepted write to address 0–9 updates that shadow entry and sets its bit in the 10-bit dirty mask.
  - An accepted write to address 10–15 is dropped and sets err_addr.
  - commit_req = 1 and dirty ≠ 0 → ARMED.
  - commit_req = 1 and dirty = 0 → ACK; no swap, no flush.
  - A write and commit_req in the same cycle: the write is applied first, counts toward dirty, and is included in the commit.
- **ARMED.**
  - wr_ready = 0.
  - Waits for sample_tick. On sample_tick: active ← shadow, dirty ← 0.
  - Then → FLUSH if FLUSH_ON_SWAP = 1, else → ACK.
- **FLUSH.** filt_clear = 1 for exactly FLUSH_CYCLES cycles, counted by a down-counter, then → ACK.
- **ACK.**
  - commit_ack = 1 for one cycle; err_addr is cleared in this cycle.
  - Then → IDLE.
  - commit_req is ignored in the ACK cycle. The requester holds commit_req until it sees commit_ack, then drops it.
- sample_tick outside ARMED is ignored.
- The shadow bank is not modified by a swap; it keeps its contents for incremental updates.
- Active outputs change only on a swap edge. They are never partially updated.
- Asserting rst_n low mid-commit, in any state, immediately restores the reset values; a pending swap is abandoned.

## Timing
- Write accepted at edge k → shadow entry visible internally at k+1. Writes have no output effect until commit.
- commit_req high in IDLE at edge k → ARMED from k+1; busy = 1 from k+1.
- sample_tick high in ARMED at edge m:
  - New coefficients appear on the outputs from cycle m+1.
  - With FLUSH_ON_SWAP = 1: filt_clear high in cycles m+1 … m+FLUSH_CYCLES; commit_ack high in cycle m+FLUSH_CYCLES+1; IDLE from m+FLUSH_CYCLES+2.
  - With FLUSH_ON_SWAP = 0: commit_ack high in cycle m+1; IDLE from m+2.
- Commit with dirty = 0, requested at edge k: commit_ack high in cycle k+1; IDLE from k+2.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- **Shared package iir_ctrl_pkg:**
  - coefficient address constants (ADDR_B0_EVEN … ADDR_A2_ODD, NUM_COEFF = 10);
  - state enum (IDLE, ARMED, FLUSH, ACK);
  - function UNITY(width).
- **Sub-module iir_coeff_bank:**
  - holds the 10-entry shadow register file, the dirty mask, and the 10-entry active register file;
  - inputs: write port, swap strobe;
  - outputs: ten active coefficients, dirty_any.
- **Top level** contains the FSM, the flush counter, err_addr, and the handshake outputs.

## Test plan
- Reset: release rst_n, no stimulus → b0_even = b0_odd = 0x4000, all other coefficients 0, wr_ready = 1, busy = 0.
- Write 0x2000 to address 0 and 0xC000 to address 8, commit, sample_tick 5 cycles later → outputs unchanged until the tick. Then b0_even = 0x2000, a1_odd = 0xC000; filt_clear high for 2 cycles; commit_ack high in the third cycle after the tick.
- Write and commit_req in the same cycle (address 3 = 0x1234) → a1_even = 0x1234 after the next sample_tick. A second commit with no writes → commit_ack one cycle later, no filt_clear.
- Write to address 12 → err_addr = 1, outputs unchanged. err_addr clears in the next commit_ack cycle.
- During ARMED, wr_valid held high → wr_ready = 0, no write accepted; the write completes after return to IDLE.
- Drop rst_n during FLUSH → filt_clear = 0 and passthrough coefficients restored immediately, without waiting for a clock edge. The FLUSH_ON_SWAP = 0 build gives commit_ack in the cycle after the tick.
